// File: rtl/psum_acc_sequencer_if.sv
// Handshake and psum-memory control bundle between the accumulation sequencer
// and its surroundings (psum memory, SFU, output consumer).
interface psum_acc_sequencer_if #(
    parameter int addr_bw = 11,
    parameter int idx_bw  = 4
);
    logic               start;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic               pmem_cen;
    logic               pmem_wen;
    logic [addr_bw-1:0] pmem_addr;
    logic               acc;
    logic               sfu_clr;
    logic               out_valid;
    logic [idx_bw-1:0]  out_idx;

    modport master (
        input  start, out_ready,
        output busy, done, pmem_cen, pmem_wen, pmem_addr,
               acc, sfu_clr, out_valid, out_idx
    );

    modport slave (
        output start, out_ready,
        input  busy, done, pmem_cen, pmem_wen, pmem_addr,
               acc, sfu_clr, out_valid, out_idx
    );
endinterface

// File: rtl/psum_acc_sequencer.sv
// Reads back the psum scratchpad for each output pixel (K*K reads), strobes the
// SFU clear/accumulate controls and hands each finished output to a consumer.
module psum_acc_sequencer #(
    parameter int o_dim   = 4,
    parameter int k_dim   = 3,
    parameter int i_dim   = 6,
    parameter int addr_bw = 11,
    parameter int idx_bw  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    psum_acc_sequencer_if.master bus
);
    localparam int LEN_KIJ  = k_dim * k_dim;
    localparam int LEN_NIJ  = i_dim * i_dim;
    localparam int LEN_ONIJ = o_dim * o_dim;
    localparam int KW       = $clog2(LEN_KIJ + 1);
    localparam int CW       = $clog2(o_dim + k_dim + 1);

    localparam logic [KW-1:0]      KIJ_LAST   = KW'(LEN_KIJ - 1);
    localparam logic [CW-1:0]      KX_LAST    = CW'(k_dim - 1);
    localparam logic [CW-1:0]      OX_LAST    = CW'(o_dim - 1);
    localparam logic [idx_bw-1:0]  ONIJ_LAST  = idx_bw'(LEN_ONIJ - 1);
    localparam logic [addr_bw-1:0] NIJ_STEP   = addr_bw'(LEN_NIJ);
    // Offset jumps that wrap a column counter onto the next input row.
    localparam logic [addr_bw-1:0] ROW_STEP_K = addr_bw'(i_dim - k_dim + 1);
    localparam logic [addr_bw-1:0] ROW_STEP_O = addr_bw'(i_dim - o_dim + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RD, S_DRAIN, S_SETTLE, S_OUT, S_DONE
    } state_t;

    state_t             state, state_n;
    logic [idx_bw-1:0]  onij, onij_n;
    logic [CW-1:0]      ox, ox_n;
    logic [CW-1:0]      kx, kx_n;
    logic [KW-1:0]      kij, kij_n;
    // pbase = oy*i_dim+ox, woff = ky*i_dim+kx, kbase = kij*len_nij
    logic [addr_bw-1:0] pbase, pbase_n;
    logic [addr_bw-1:0] woff, woff_n;
    logic [addr_bw-1:0] kbase, kbase_n;

    logic               rd_n;
    logic               acc_n;
    logic [addr_bw-1:0] addr_n;

    always_comb begin
        state_n = state;
        onij_n  = onij;
        ox_n    = ox;
        kx_n    = kx;
        kij_n   = kij;
        pbase_n = pbase;
        woff_n  = woff;
        kbase_n = kbase;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_CLR;
                    onij_n  = '0;
                    ox_n    = '0;
                    pbase_n = '0;
                end
            end
            S_CLR: begin
                state_n = S_RD;
                kij_n   = '0;
                kx_n    = '0;
                woff_n  = '0;
                kbase_n = '0;
            end
            S_RD: begin
                if (kij == KIJ_LAST) begin
                    state_n = S_DRAIN;
                end else begin
                    kij_n   = kij + 1'b1;
                    kbase_n = kbase + NIJ_STEP;
                    if (kx == KX_LAST) begin
                        kx_n   = '0;
                        woff_n = woff + ROW_STEP_K;
                    end else begin
                        kx_n   = kx + 1'b1;
                        woff_n = woff + 1'b1;
                    end
                end
            end
            S_DRAIN:  state_n = S_SETTLE;
            S_SETTLE: state_n = S_OUT;
            S_OUT: begin
                if (bus.out_valid && bus.out_ready) begin
                    if (onij == ONIJ_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_CLR;
                        onij_n  = onij + 1'b1;
                        if (ox == OX_LAST) begin
                            ox_n    = '0;
                            pbase_n = pbase + ROW_STEP_O;
                        end else begin
                            ox_n    = ox + 1'b1;
                            pbase_n = pbase + 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered with it.
    always_comb begin
        rd_n   = (state_n == S_RD);
        acc_n  = (rd_n && (kij_n != '0)) || (state_n == S_DRAIN);
        addr_n = rd_n ? (kbase_n + pbase_n + woff_n) : bus.pmem_addr;
    end

    assign bus.pmem_wen = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            onij          <= '0;
            ox            <= '0;
            kx            <= '0;
            kij           <= '0;
            pbase         <= '0;
            woff          <= '0;
            kbase         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pmem_cen  <= 1'b1;
            bus.pmem_addr <= '0;
            bus.acc       <= 1'b0;
            bus.sfu_clr   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
        end else begin
            state         <= state_n;
            onij          <= onij_n;
            ox            <= ox_n;
            kx            <= kx_n;
            kij           <= kij_n;
            pbase         <= pbase_n;
            woff          <= woff_n;
            kbase         <= kbase_n;
            bus.busy      <= (state_n != S_IDLE) && (state_n != S_DONE);
            bus.done      <= (state_n == S_DONE);
            bus.pmem_cen  <= !rd_n;
            bus.pmem_addr <= addr_n;
            bus.acc       <= acc_n;
            bus.sfu_clr   <= (state_n == S_CLR);
            bus.out_valid <= (state_n == S_OUT);
            bus.out_idx   <= (state_n == S_OUT) ? onij_n : bus.out_idx;
        end
    end
endmodule

// File: tb/tb_psum_acc_sequencer.sv
// Bench for psum_acc_sequencer: fixed-cycle vector table on a free-running pass,
// plus scoreboarded passes with stalls, random back-pressure, stray starts and reset.
module tb_psum_acc_sequencer;
    localparam int O = 4;
    localparam int K = 3;
    localparam int I = 6;
    localparam int BUDGET  = 3000;
    localparam int TRACE_N = 256;
    localparam int NV      = 19;

    typedef struct {
        int cyc; int cen; int addr; int acc; int clr; int valid; int idx; int busy; int done;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vec [NV];
    vec_t tr  [TRACE_N];

    psum_acc_sequencer_if #(.addr_bw(11), .idx_bw(4)) bus ();

    psum_acc_sequencer #(
        .o_dim(O), .k_dim(K), .i_dim(I), .addr_bw(11), .idx_bw(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Address of the kij-th contributor of output pixel onij, straight from the layout.
    function automatic int ref_addr(input int onij, input int kij);
        return kij * I * I + (onij / O + kij / K) * I + (onij % O + kij % K);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_busy"},      int'(bus.busy),      0);
        check({tag, "_done"},      int'(bus.done),      0);
        check({tag, "_cen"},       int'(bus.pmem_cen),  1);
        check({tag, "_wen"},       int'(bus.pmem_wen),  1);
        check({tag, "_addr"},      int'(bus.pmem_addr), 0);
        check({tag, "_acc"},       int'(bus.acc),       0);
        check({tag, "_clr"},       int'(bus.sfu_clr),   0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_out_idx"},   int'(bus.out_idx),   0);
    endtask

    // mode 0: ready high; 1: random ready; 2: 5-cycle stall at output 7; 3: stray starts
    task automatic run_pass(input int mode);
        int q[$];
        int cyc = 1, onij = 0, acc_cnt = 0, clr_cnt = 0, stalls = 0, hold7 = 0;
        int done_cyc = -1, bad_wen = 0, bad_quiet = 0;
        bit expect_clr = 0, finished = 0;
        for (int o = 0; o < O * O; o++)
            for (int k = 0; k < K * K; k++)
                q.push_back(ref_addr(o, k));
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        while (!finished && cyc < BUDGET) begin
            if (cyc < TRACE_N)
                tr[cyc] = '{cyc, int'(bus.pmem_cen), int'(bus.pmem_addr), int'(bus.acc),
                            int'(bus.sfu_clr), int'(bus.out_valid), int'(bus.out_idx),
                            int'(bus.busy), int'(bus.done)};
            if (bus.pmem_wen !== 1'b1) bad_wen++;
            if (bus.pmem_cen === 1'b0) begin
                if (q.size() == 0) check("extra_read", 1, 0);
                else check("rd_addr", int'(bus.pmem_addr), q.pop_front());
            end
            if (bus.acc === 1'b1) acc_cnt++;
            if (bus.sfu_clr === 1'b1) clr_cnt++;
            if (bus.out_valid === 1'b1 && (bus.pmem_cen !== 1'b1 || bus.acc !== 1'b0)) bad_quiet++;
            if (expect_clr) begin
                check("resume_clr", int'(bus.sfu_clr), 1);
                expect_clr = 0;
            end
            if (done_cyc >= 0) begin
                check("done_single_pulse", int'(bus.done), 0);
                check("busy_after_done", int'(bus.busy), 0);
                finished = 1;
            end else begin
                if (bus.done === 1'b1) begin
                    done_cyc = cyc;
                    check("busy_at_done", int'(bus.busy), 0);
                end
                bus.out_ready = 1'b1;
                if (mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
                if (mode == 2 && bus.out_valid === 1'b1 && int'(bus.out_idx) == 7 && hold7 < 5) begin
                    bus.out_ready = 1'b0;
                    hold7++;
                end
                if (mode == 3) bus.start = (bus.done !== 1'b1) && ($urandom_range(0, 2) == 0);
                if (bus.out_valid === 1'b1) begin
                    if (bus.out_ready) begin
                        check("out_idx", int'(bus.out_idx), onij);
                        check("acc_per_out", acc_cnt, K * K);
                        check("clr_per_out", clr_cnt, 1);
                        if (mode == 2 && onij == 7) begin
                            check("stall_len", hold7, 5);
                            expect_clr = 1;
                        end
                        acc_cnt = 0;
                        clr_cnt = 0;
                        onij++;
                    end else begin
                        stalls++;
                    end
                end
                step();
                cyc++;
            end
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        check("finished_in_budget", int'(finished), 1);
        check("outputs_seen", onij, O * O);
        check("reads_left", q.size(), 0);
        check("done_cycle", done_cyc, (O * O) * (K * K + 4) + 1 + stalls);
        check("wen_always_high", bad_wen, 0);
        check("quiet_while_valid", bad_quiet, 0);
    endtask

    initial begin
        //        cyc cen addr acc clr vld idx busy done
        vec[0]  = '{1,   1, -1,  0, 1, 0, -1, 1, 0};
        vec[1]  = '{2,   0,  0,  0, 0, 0, -1, 1, 0};
        vec[2]  = '{3,   0, 37,  1, 0, 0, -1, 1, 0};
        vec[3]  = '{5,   0, 114, 1, 0, 0, -1, 1, 0};
        vec[4]  = '{10,  0, 302, 1, 0, 0, -1, 1, 0};
        vec[5]  = '{11,  1, -1,  1, 0, 0, -1, 1, 0};
        vec[6]  = '{12,  1, -1,  0, 0, 0, -1, 1, 0};
        vec[7]  = '{13,  1, -1,  0, 0, 1,  0, 1, 0};
        vec[8]  = '{14,  1, -1,  0, 1, 0, -1, 1, 0};
        vec[9]  = '{54,  0,  6,  0, 0, 0, -1, 1, 0};
        vec[10] = '{58,  0, 157, 1, 0, 0, -1, 1, 0};
        vec[11] = '{62,  0, 308, 1, 0, 0, -1, 1, 0};
        vec[12] = '{65,  1, -1,  0, 0, 1,  4, 1, 0};
        vec[13] = '{197, 0, 21,  0, 0, 0, -1, 1, 0};
        vec[14] = '{201, 0, 172, 1, 0, 0, -1, 1, 0};
        vec[15] = '{205, 0, 323, 1, 0, 0, -1, 1, 0};
        vec[16] = '{208, 1, -1,  0, 0, 1, 15, 1, 0};
        vec[17] = '{209, 1, -1,  0, 0, 0, -1, 0, 1};
        vec[18] = '{210, 1, -1,  0, 0, 0, -1, 0, 0};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        check_reset("por");
        reset = 1'b0;
        step();

        run_pass(0);
        for (int i = 0; i < NV; i++) begin
            vec_t v = vec[i];
            vec_t o = tr[v.cyc];
            if (v.cen   >= 0) check($sformatf("c%0d_cen",   v.cyc), o.cen,   v.cen);
            if (v.addr  >= 0) check($sformatf("c%0d_addr",  v.cyc), o.addr,  v.addr);
            if (v.acc   >= 0) check($sformatf("c%0d_acc",   v.cyc), o.acc,   v.acc);
            if (v.clr   >= 0) check($sformatf("c%0d_clr",   v.cyc), o.clr,   v.clr);
            if (v.valid >= 0) check($sformatf("c%0d_valid", v.cyc), o.valid, v.valid);
            if (v.idx   >= 0) check($sformatf("c%0d_idx",   v.cyc), o.idx,   v.idx);
            if (v.busy  >= 0) check($sformatf("c%0d_busy",  v.cyc), o.busy,  v.busy);
            if (v.done  >= 0) check($sformatf("c%0d_done",  v.cyc), o.done,  v.done);
        end

        run_pass(2);
        run_pass(1);
        run_pass(3);

        // Reset in the middle of the reads for output 3, then a clean restart.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (43) step();
        check("pre_reset_cen", int'(bus.pmem_cen), 0);
        check("pre_reset_addr", int'(bus.pmem_addr), ref_addr(3, 3));
        reset = 1'b1;
        step();
        check_reset("midpass");
        reset = 1'b0;
        step();
        run_pass(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
